// File: rtl/w_buffer_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : w_buffer_pingpong
// Purpose  : Ping-pong weight buffer feeding the top edge of a systolic array.
// Revision : 1.0 - initial release
// ============================================================================
module w_buffer_pingpong #(
   parameter int RAM_SIZE   = 256,
   parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
   parameter int ARRAY_N    = 8,
   parameter int ARRAY_M    = 8,
   parameter int WGT_WIDTH  = 8,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
   localparam int COL_W     = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wr_valid,
   output logic                           wr_ready,
   input  logic [COL_W-1:0]               wr_col,
   input  logic [ADDR_WIDTH-1:0]          wr_addr,
   input  logic [WGT_WIDTH-1:0]           wr_data,
   input  logic                           wr_commit,
   input  logic                           rd_start,
   output logic                           rd_ready,
   input  logic                           rd_mode,
   input  logic [ADDR_WIDTH-1:0]          rd_base_addr,
   input  logic [LEN_WIDTH-1:0]           rd_length,
   input  logic [COL_W:0]                 rd_num_cols,
   input  logic                           rd_release,
   output logic [ARRAY_M*WGT_WIDTH-1:0]   wgt_data_set_out,
   output logic [ARRAY_M-1:0]             wgt_valid,
   output logic                           rd_busy,
   output logic                           rd_done
);

   localparam int T_W = LEN_WIDTH + 1;

   if ((RAM_SIZE != (1 << ADDR_WIDTH)) || (ARRAY_N < 1) || (ARRAY_M < 1)) begin : g_param_check
      $error("w_buffer_pingpong: RAM_SIZE must be a power of two and ARRAY_N/ARRAY_M >= 1");
   end

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;

   logic [1:0]            r_state;
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_full;
   logic [1:0]            w_full_next;
   logic                  r_mode;
   logic                  r_release;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [COL_W:0]        r_cols;
   logic [T_W-1:0]        r_t;
   logic [T_W-1:0]        w_tail;
   logic [T_W-1:0]        w_t_done;
   logic                  w_wr_fire;
   logic                  w_commit_ok;
   logic                  w_accept;
   logic                  w_done;

   logic                  w_active;
   logic                  w_mode;
   logic [T_W-1:0]        w_t;
   logic [T_W-1:0]        w_len;
   logic [ADDR_WIDTH-1:0] w_base;
   logic [COL_W:0]        w_cols;

   assign wr_ready    = ~r_full[r_wr_ptr];
   assign rd_ready    = (r_state == S_IDLE) & r_full[r_rd_ptr];
   assign rd_busy     = (r_state != S_IDLE);
   assign w_wr_fire   = wr_valid & wr_ready;
   assign w_commit_ok = wr_commit & ~r_full[r_wr_ptr];
   assign w_accept    = rd_start & rd_ready;

   // r_t counts cycles since accept; the last DRAIN cycle covers skew tail plus read latency
   assign w_tail   = r_mode ? (T_W'(r_cols) - T_W'(1)) : '0;
   assign w_t_done = T_W'(r_len) + w_tail + T_W'(1);
   assign w_done   = (r_state == S_DRAIN) && (r_t == w_t_done);
   assign rd_done  = w_done;

   always_comb begin
      w_full_next = r_full;
      if (w_commit_ok) w_full_next[r_wr_ptr] = 1'b1;
      if (w_done && r_release) w_full_next[r_rd_ptr] = 1'b0;
   end

   // Reads are issued one cycle ahead of the output, so the accept cycle uses the live request
   assign w_active = w_accept | rd_busy;
   assign w_mode   = w_accept ? rd_mode : r_mode;
   assign w_t      = w_accept ? '0 : r_t;
   assign w_len    = w_accept ? T_W'(rd_length) : T_W'(r_len);
   assign w_base   = w_accept ? rd_base_addr : r_base;
   assign w_cols   = w_accept ? rd_num_cols : r_cols;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_full    <= 2'b00;
         r_mode    <= 1'b0;
         r_release <= 1'b0;
         r_base    <= '0;
         r_len     <= '0;
         r_cols    <= '0;
         r_t       <= '0;
      end else begin
         r_full <= w_full_next;
         if (w_commit_ok) r_wr_ptr <= ~r_wr_ptr;
         if (w_done && r_release) r_rd_ptr <= ~r_rd_ptr;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mode    <= rd_mode;
                  r_base    <= rd_base_addr;
                  r_len     <= rd_length;
                  r_cols    <= rd_num_cols;
                  r_release <= rd_release;
                  r_t       <= T_W'(1);
                  r_state   <= S_STREAM;
               end
            end
            S_STREAM: begin
               r_t <= r_t + T_W'(1);
               if (r_t == T_W'(r_len)) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               r_t <= r_t + T_W'(1);
               if (w_done) begin
                  r_state <= S_IDLE;
                  r_t     <= '0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   for (genvar m = 0; m < ARRAY_M; m++) begin : g_col
      logic [WGT_WIDTH-1:0]  mem [0:1][0:RAM_SIZE-1];
      logic [T_W-1:0]        w_k;
      logic                  w_issue;
      logic [ADDR_WIDTH-1:0] w_addr;
      logic [WGT_WIDTH-1:0]  r_data;
      logic                  r_valid;

      assign w_k     = w_mode ? (w_t - T_W'(m)) : w_t;
      assign w_issue = w_active && ((COL_W+1)'(m) < w_cols) &&
                       (!w_mode || (w_t >= T_W'(m))) && (w_k < w_len);
      assign w_addr  = ADDR_WIDTH'(T_W'(w_base) + w_k);

      always_ff @(posedge clk) begin
         if (w_wr_fire && (wr_col == COL_W'(m))) mem[r_wr_ptr][wr_addr] <= wr_data;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
         end else if (w_issue) begin
            r_data  <= mem[r_rd_ptr][w_addr];
            r_valid <= 1'b1;
         end else begin
            r_data  <= '0;
            r_valid <= 1'b0;
         end
      end

      assign wgt_data_set_out[m*WGT_WIDTH +: WGT_WIDTH] = r_data;
      assign wgt_valid[m] = r_valid;
   end

endmodule
`default_nettype wire

// File: tb/tb_w_buffer_pingpong.sv
`default_nettype none
// Testbench for w_buffer_pingpong: scoreboard of expected per-column beats
// built from a shadow copy of both banks.
module tb_w_buffer_pingpong;
   localparam int RAM_SIZE = 256;
   localparam int AW = 8;
   localparam int M  = 8;
   localparam int W  = 8;
   localparam int LW = 9;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [CW-1:0] wr_col = '0;
   logic [AW-1:0] wr_addr = '0;
   logic [W-1:0]  wr_data = '0;
   logic          wr_commit = 1'b0;
   logic          rd_start = 1'b0;
   logic          rd_ready;
   logic          rd_mode = 1'b0;
   logic [AW-1:0] rd_base_addr = '0;
   logic [LW-1:0] rd_length = '0;
   logic [CW:0]   rd_num_cols = '0;
   logic          rd_release = 1'b0;
   logic [M*W-1:0] wgt_data_set_out;
   logic [M-1:0]  wgt_valid;
   logic          rd_busy;
   logic          rd_done;

   w_buffer_pingpong #(.RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .ARRAY_N(8), .ARRAY_M(M),
                       .WGT_WIDTH(W), .LEN_WIDTH(LW)) dut (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit), .rd_start(rd_start),
      .rd_ready(rd_ready), .rd_mode(rd_mode), .rd_base_addr(rd_base_addr),
      .rd_length(rd_length), .rd_num_cols(rd_num_cols), .rd_release(rd_release),
      .wgt_data_set_out(wgt_data_set_out), .wgt_valid(wgt_valid), .rd_busy(rd_busy),
      .rd_done(rd_done));

   always #5 clk = ~clk;

   typedef struct { int col; int cyc; logic [7:0] data; } exp_t;
   exp_t       q[$];
   logic [7:0] m_mem [2][M][RAM_SIZE];
   logic [1:0] m_full = 2'b00;
   logic       m_wr = 1'b0;
   logic       m_rd = 1'b0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic       ready_at_done;
   logic       ready_after;
   logic [7:0] mon_got;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: expected beats are ordered by cycle, then column
   always @(negedge clk) begin
      if (!reset) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missing_beat col=%0d cyc=%0d exp=%0d got=no beat", q[0].col, q[0].cyc, q[0].data);
            void'(q.pop_front());
         end
         for (int m = 0; m < M; m++) begin
            mon_got = wgt_data_set_out[m*W +: W];
            if (wgt_valid[m]) begin
               checks++;
               if (q.size() > 0 && q[0].col == m && q[0].cyc == cyc) begin
                  if (mon_got !== q[0].data) begin
                     errors++;
                     $display("FAIL beat_data col=%0d cyc=%0d got=%0d exp=%0d", m, cyc, mon_got, q[0].data);
                  end
                  void'(q.pop_front());
               end else begin
                  errors++;
                  $display("FAIL unexpected_beat col=%0d cyc=%0d got=%0d exp=no beat", m, cyc, mon_got);
               end
            end else begin
               if (q.size() > 0 && q[0].col == m && q[0].cyc == cyc) begin
                  checks++; errors++;
                  $display("FAIL missing_beat col=%0d cyc=%0d exp=%0d got=valid low", m, cyc, q[0].data);
                  void'(q.pop_front());
               end
               checks++;
               if (mon_got !== 8'd0) begin
                  errors++;
                  $display("FAIL idle_data col=%0d cyc=%0d got=%0d exp=0", m, cyc, mon_got);
               end
            end
         end
      end
   end

   function automatic logic [7:0] pattern(input int bank, input int m, input int a);
      logic [7:0] v;
      v = 8'((m * 16 + a) & 255);
      return bank ? (v ^ 8'h5A) : v;
   endfunction

   task automatic write_beat(input int col, input int addr, input logic [7:0] data);
      wr_valid = 1'b1; wr_col = CW'(col); wr_addr = AW'(addr); wr_data = data;
      if (!m_full[m_wr]) m_mem[m_wr][col][addr] = data;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic fill_bank(input int bank);
      for (int m = 0; m < M; m++)
         for (int a = 0; a < RAM_SIZE; a++)
            write_beat(m, a, pattern(bank, m, a));
   endtask

   task automatic commit();
      wr_commit = 1'b1;
      if (!m_full[m_wr]) begin m_full[m_wr] = 1'b1; m_wr = ~m_wr; end
      @(negedge clk);
      wr_commit = 1'b0;
   endtask

   task automatic start_stream(input logic mode, input int base, input int len, input int cols,
                               input logic rel, output int done_cyc);
      int   a_cyc, tail, k;
      exp_t e;
      checks++;
      if (rd_ready !== m_full[m_rd]) begin
         errors++; $display("FAIL rd_ready_at_start got=%b exp=%b", rd_ready, m_full[m_rd]);
      end
      a_cyc = cyc;
      tail  = mode ? cols - 1 : 0;
      for (int t = 0; t < len + tail; t++)
         for (int m = 0; m < cols; m++) begin
            k = mode ? t - m : t;
            if (k >= 0 && k < len) begin
               e.col = m; e.cyc = a_cyc + 1 + t; e.data = m_mem[m_rd][m][(base + k) % RAM_SIZE];
               q.push_back(e);
            end
         end
      rd_start = 1'b1; rd_mode = mode; rd_base_addr = AW'(base); rd_length = LW'(len);
      rd_num_cols = (CW+1)'(cols); rd_release = rel;
      @(negedge clk);
      rd_start = 1'b0;
      done_cyc = a_cyc + len + tail + 1;
   endtask

   task automatic wait_done(input int exp_cyc, input logic rel, input string name);
      int seen;
      seen = -1;
      for (int i = 0; i < 1000; i++) begin
         if (rd_done === 1'b1) begin seen = cyc; break; end
         @(negedge clk);
      end
      checks++;
      if (seen != exp_cyc) begin
         errors++; $display("FAIL %s_done_cycle got=%0d exp=%0d", name, seen, exp_cyc);
      end
      ready_at_done = wr_ready;
      if (rel) begin m_full[m_rd] = 1'b0; m_rd = ~m_rd; end
      @(negedge clk);
      ready_after = wr_ready;
      checks++;
      if (rd_done !== 1'b0 || rd_busy !== 1'b0) begin
         errors++; $display("FAIL %s_idle_after got done=%b busy=%b exp done=0 busy=0", name, rd_done, rd_busy);
      end
      checks++;
      if (q.size() != 0) begin
         errors++; $display("FAIL %s_leftover got=%0d exp=0 pending beats", name, q.size());
      end
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if (wr_ready !== 1'b1 || rd_ready !== 1'b0 || rd_busy !== 1'b0 || rd_done !== 1'b0 ||
          wgt_valid !== '0 || wgt_data_set_out !== '0) begin
         errors++;
         $display("FAIL %s got wr_ready=%b rd_ready=%b busy=%b done=%b valid=%h data=%h exp 1 0 0 0 0 0",
                  name, wr_ready, rd_ready, rd_busy, rd_done, wgt_valid, wgt_data_set_out);
      end
   endtask

   task automatic test_reset();
      int d;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_idle_outputs("reset_initial");
      for (int a = 0; a < 4; a++) write_beat(0, a, 8'h11 + 8'(a));
      commit();
      checks++;
      if (rd_ready !== 1'b1) begin errors++; $display("FAIL commit_rd_ready got=%b exp=1", rd_ready); end
      start_stream(1'b1, 0, 4, 1, 1'b0, d);
      @(negedge clk);
      reset = 1'b1;
      q.delete();
      @(negedge clk);
      check_idle_outputs("reset_mid_stream");
      reset = 1'b0;
      m_full = 2'b00; m_wr = 1'b0; m_rd = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset_released");
   endtask

   task automatic test_os_stream();
      int d;
      fill_bank(0);
      commit();
      start_stream(1'b1, 0, 4, 8, 1'b0, d);
      wait_done(d, 1'b0, "os");
   endtask

   task automatic test_ws_partial_reuse();
      int d;
      start_stream(1'b0, 10, 2, 3, 1'b0, d);
      wait_done(d, 1'b0, "ws_partial");
      start_stream(1'b0, 10, 2, 3, 1'b0, d);
      wait_done(d, 1'b0, "ws_reuse");
   endtask

   task automatic test_wrap();
      int d;
      start_stream(1'b1, 254, 4, 8, 1'b0, d);
      wait_done(d, 1'b0, "wrap_os");
      start_stream(1'b0, 255, 3, 8, 1'b0, d);
      wait_done(d, 1'b0, "wrap_ws");
   endtask

   task automatic test_ignore_busy();
      int d;
      start_stream(1'b1, 20, 8, 8, 1'b0, d);
      @(negedge clk);
      checks++;
      if (rd_ready !== 1'b0 || rd_busy !== 1'b1) begin
         errors++; $display("FAIL busy_flags got rd_ready=%b busy=%b exp 0 1", rd_ready, rd_busy);
      end
      rd_start = 1'b1; rd_mode = 1'b0; rd_base_addr = 8'd100; rd_length = 9'd3; rd_num_cols = 4'd2;
      @(negedge clk);
      rd_start = 1'b0;
      wait_done(d, 1'b0, "busy_ignore");
   endtask

   task automatic test_ping_pong();
      int d;
      fork
         begin fill_bank(1); commit(); end
         begin start_stream(1'b1, 32, 16, 8, 1'b0, d); wait_done(d, 1'b0, "pp_concurrent"); end
      join
      checks++;
      if (wr_ready !== 1'b0) begin errors++; $display("FAIL both_full_wr_ready got=%b exp=0", wr_ready); end
      commit();
      checks++;
      if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_commit_wr_ready got=%b exp=0", wr_ready); end
      for (int i = 0; i < 3; i++) write_beat(0, 32 + i, 8'hEE);
      start_stream(1'b1, 32, 16, 8, 1'b1, d);
      wait_done(d, 1'b1, "pp_release");
      checks++;
      if (ready_at_done !== 1'b0 || ready_after !== 1'b1) begin
         errors++; $display("FAIL release_wr_ready got at_done=%b after=%b exp 0 1", ready_at_done, ready_after);
      end
      start_stream(1'b0, 0, 8, 8, 1'b0, d);
      wait_done(d, 1'b0, "pp_bank1");
   endtask

   task automatic test_release_commit();
      int d;
      for (int m = 0; m < M; m++)
         for (int a = 0; a < 4; a++) write_beat(m, a, 8'hC0 + 8'(m * 4 + a));
      start_stream(1'b0, 4, 4, 8, 1'b1, d);
      for (int i = 0; i < 100 && cyc < d; i++) @(negedge clk);
      checks++;
      if (rd_done !== 1'b1) begin errors++; $display("FAIL rc_done_cycle got=%b exp=1 at cyc %0d", rd_done, d); end
      wr_commit = 1'b1;
      m_full[m_wr] = 1'b1; m_wr = ~m_wr;
      m_full[m_rd] = 1'b0; m_rd = ~m_rd;
      @(negedge clk);
      wr_commit = 1'b0;
      checks++;
      if (rd_ready !== 1'b1 || wr_ready !== 1'b1 || rd_busy !== 1'b0) begin
         errors++; $display("FAIL rc_flags got rd_ready=%b wr_ready=%b busy=%b exp 1 1 0", rd_ready, wr_ready, rd_busy);
      end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL rc_leftover got=%0d exp=0", q.size()); end
      start_stream(1'b1, 0, 40, 8, 1'b0, d);
      wait_done(d, 1'b0, "rc_bank0");
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_os_stream();
      test_ws_partial_reuse();
      test_wrap();
      test_ignore_busy();
      test_ping_pong();
      test_release_commit();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
